led_pattern_gen: RTL and testbench



---
 rtl/led_pattern_gen.sv | 145 ++++++++++++++
 tb/tb_led_pattern_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// Board LED pattern generator: seven display modes advanced by an internal step prescaler.
// The logical pattern P is held in pat_q; leds_q is the same value with optional inversion
// so the pins are driven straight from a flop.
module led_pattern_gen #(
  parameter int unsigned NUM_LEDS    = 4,
  parameter int unsigned STEP_CYCLES = 50000000,
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned ACTIVE_LOW  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [2:0]          mode,
  output logic [NUM_LEDS-1:0] leds,
  output logic                step_tick
);

  localparam int unsigned CntW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STEP_CYCLES - 1);

  localparam logic [NUM_LEDS-1:0] AllOnes   = {NUM_LEDS{1'b1}};
  localparam logic [NUM_LEDS-1:0] OneHotLsb = NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] OutMask   = {NUM_LEDS{ACTIVE_LOW != 0}};
  localparam logic [PWM_BITS-1:0] DutyMax   = {PWM_BITS{1'b1}};

  // Mode encodings
  localparam logic [2:0] ModeOff     = 3'd0;
  localparam logic [2:0] ModeOn      = 3'd1;
  localparam logic [2:0] ModeRun     = 3'd2;
  localparam logic [2:0] ModePing    = 3'd3;
  localparam logic [2:0] ModeBlink   = 3'd4;
  localparam logic [2:0] ModeCount   = 3'd5;
  localparam logic [2:0] ModeBreathe = 3'd6;

  // Direction shared by ping-pong (LED position) and breathe (duty)
  localparam logic DirUp   = 1'b0;
  localparam logic DirDown = 1'b1;

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          mode_q, mode_d;
  logic [NUM_LEDS-1:0] pat_q, pat_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic                dir_q, dir_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                tick_q, tick_d;

  logic tick_int;
  logic mode_chg;

  assign tick_int = en && (cnt_q == CntMax);
  assign mode_chg = (mode != mode_q);

  // Step prescaler and free-running PWM counter
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    cnt_d     = cnt_q;
    if (mode_chg) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    end
  end

  // Pattern next-state: mode change loads the initial pattern and wins over a coincident tick
  always_comb begin
    mode_d = mode_q;
    pat_d  = pat_q;
    dir_d  = dir_q;
    duty_d = duty_q;
    tick_d = 1'b0;
    if (mode_chg) begin
      mode_d = mode;
      dir_d  = DirUp;
      duty_d = '0;
      case (mode)
        ModeOn:            pat_d = AllOnes;
        ModeRun, ModePing: pat_d = OneHotLsb;
        default:           pat_d = '0;
      endcase
    end else begin
      if (tick_int) begin
        tick_d = 1'b1;
        case (mode_q)
          ModeOn:    pat_d = AllOnes;
          ModeRun:   pat_d = {pat_q[NUM_LEDS-2:0], pat_q[NUM_LEDS-1]};
          ModePing: begin
            if (dir_q == DirUp) begin
              pat_d = pat_q << 1;
              if (pat_d[NUM_LEDS-1]) dir_d = DirDown;
            end else begin
              pat_d = pat_q >> 1;
              if (pat_d[0]) dir_d = DirUp;
            end
          end
          ModeBlink: pat_d = ~pat_q;
          ModeCount: pat_d = pat_q + NUM_LEDS'(1);
          ModeBreathe: begin
            // Each endpoint is visited once, then the ramp reverses
            if (dir_q == DirUp) begin
              duty_d = duty_q + PWM_BITS'(1);
              if (duty_d == DutyMax) dir_d = DirDown;
            end else begin
              duty_d = duty_q - PWM_BITS'(1);
              if (duty_d == '0) dir_d = DirUp;
            end
          end
          default:   pat_d = '0;
        endcase
      end
      // PWM compare runs every cycle, even while frozen
      if (mode_q == ModeBreathe) begin
        pat_d = {NUM_LEDS{pwm_cnt_q < duty_q}};
      end
    end
    leds_d = pat_d ^ OutMask;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      mode_q    <= ModeOff;
      pat_q     <= '0;
      leds_q    <= OutMask;
      dir_q     <= DirUp;
      duty_q    <= '0;
      pwm_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      pat_q     <= pat_d;
      leds_q    <= leds_d;
      dir_q     <= dir_d;
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_d;
      tick_q    <= tick_d;
    end
  end

  assign leds      = leds_q;
  assign step_tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with an active-high and an active-low instance in lockstep.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] mode = 3'd2;
  logic [3:0] leds, leds_al;
  logic       tick, tick_al;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [3:0] leds;
    logic       tick;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  led_pattern_gen #(
    .NUM_LEDS(4), .STEP_CYCLES(4), .PWM_BITS(3), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .leds(leds), .step_tick(tick)
  );

  led_pattern_gen #(
    .NUM_LEDS(4), .STEP_CYCLES(4), .PWM_BITS(3), .ACTIVE_LOW(1)
  ) dut_al (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .leds(leds_al), .step_tick(tick_al)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_leds(input string name, input logic [3:0] exp);
    logic [3:0] inv;
    inv = ~exp;
    chk({name, " leds"}, 32'(leds), 32'(exp));
    chk({name, " leds_al"}, 32'(leds_al), 32'(inv));
  endtask

  task automatic chk_tick(input string name, input logic exp);
    chk({name, " tick"}, 32'(tick), 32'(exp));
    chk({name, " tick_al"}, 32'(tick_al), 32'(exp));
  endtask

  // Three idle cycles holding `hold`, then the step edge showing `exp` with a tick
  task automatic run_step(input string name, input logic [3:0] hold, input logic [3:0] exp);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk_leds({name, " idle"}, hold);
      chk_tick({name, " idle"}, 1'b0);
    end
    cycle();
    chk_leds(name, exp);
    chk_tick(name, 1'b1);
  endtask

  // Freeze steps and count lit cycles over one full 8-cycle PWM period
  task automatic measure_duty(input string name, input int exp_duty);
    int ones;
    ones = 0;
    en = 1'b0;
    cycle();
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk_tick({name, " frozen"}, 1'b0);
      if (leds == 4'hF) ones++;
    end
    chk({name, " duty"}, 32'(ones), 32'(exp_duty));
  endtask

  // Resume from a frozen cnt of 0: the step lands on the 4th edge
  task automatic advance_step(input string name);
    en = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    cycle();
    chk_tick(name, 1'b1);
  endtask

  task automatic add(input logic r, input logic e, input logic [2:0] m,
                     input logic [3:0] l, input logic t);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.leds = l; v.tick = t;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] pp[8];
    logic [3:0] e, p;

    // Reset for 3 cycles, then RUN stepping every 4 cycles
    add(1, 0, 2, 4'b0000, 0);
    add(1, 0, 2, 4'b0000, 0);
    add(1, 0, 2, 4'b0000, 0);
    add(0, 1, 2, 4'b0001, 0);
    add(0, 1, 2, 4'b0001, 0);
    add(0, 1, 2, 4'b0001, 0);
    add(0, 1, 2, 4'b0001, 0);
    add(0, 1, 2, 4'b0010, 1);
    add(0, 1, 2, 4'b0010, 0);
    add(0, 1, 2, 4'b0010, 0);
    add(0, 1, 2, 4'b0010, 0);
    add(0, 1, 2, 4'b0100, 1);
    add(0, 1, 2, 4'b0100, 0);
    add(0, 1, 2, 4'b0100, 0);
    add(0, 1, 2, 4'b0100, 0);
    add(0, 1, 2, 4'b1000, 1);
    add(0, 1, 2, 4'b1000, 0);
    add(0, 1, 2, 4'b1000, 0);
    add(0, 1, 2, 4'b1000, 0);
    add(0, 1, 2, 4'b0001, 1);
    add(0, 1, 2, 4'b0001, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst  = vecs[i].rst;
      en   = vecs[i].en;
      mode = vecs[i].mode;
      cycle();
      chk_leds($sformatf("vec%0d", i), vecs[i].leds);
      chk_tick($sformatf("vec%0d", i), vecs[i].tick);
    end

    // PINGPONG
    pp[0] = 4'b0010; pp[1] = 4'b0100; pp[2] = 4'b1000; pp[3] = 4'b0100;
    pp[4] = 4'b0010; pp[5] = 4'b0001; pp[6] = 4'b0010; pp[7] = 4'b0100;
    mode = 3'd3;
    cycle();
    chk_leds("ping init", 4'b0001);
    chk_tick("ping init", 1'b0);
    p = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      run_step($sformatf("ping%0d", k), p, pp[k]);
      p = pp[k];
    end

    // COUNT through a full wrap and on to 0101
    mode = 3'd5;
    cycle();
    chk_leds("count init", 4'b0000);
    for (int k = 1; k <= 21; k++) begin
      e = 4'(k);
      p = 4'(k - 1);
      run_step($sformatf("count%0d", k), p, e);
    end

    // Freeze at 0101
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk_leds("count frozen", 4'b0101);
      chk_tick("count frozen", 1'b0);
    end
    en = 1'b1;
    run_step("count resume", 4'b0101, 4'b0110);

    // Mode change mid-step restarts the prescaler
    mode = 3'd2;
    cycle();
    chk_leds("run2 init", 4'b0001);
    run_step("run2 s1", 4'b0001, 4'b0010);
    run_step("run2 s2", 4'b0010, 4'b0100);
    cycle();
    cycle();
    chk_leds("run2 cnt2", 4'b0100);
    mode = 3'd4;
    cycle();
    chk_leds("blink init", 4'b0000);
    chk_tick("blink init", 1'b0);
    run_step("blink s1", 4'b0000, 4'b1111);

    // BREATHE ramp
    mode = 3'd6;
    cycle();
    chk_leds("br init", 4'b0000);
    run_step("br s1", 4'b0000, 4'b0000);
    for (int s = 2; s <= 3; s++) begin
      for (int i = 0; i < 3; i++) cycle();
      cycle();
      chk_tick($sformatf("br s%0d", s), 1'b1);
    end
    measure_duty("br d3", 3);
    for (int d = 4; d <= 7; d++) begin
      advance_step($sformatf("br up%0d", d));
      measure_duty($sformatf("br d%0d", d), d);
    end
    advance_step("br down6");
    measure_duty("br d6 down", 6);

    // Reset mid-ramp
    en = 1'b1;
    rst = 1'b1;
    cycle();
    chk_leds("br rst", 4'b0000);
    chk_tick("br rst", 1'b0);
    rst = 1'b0;
    cycle();
    chk_leds("br restart", 4'b0000);
    run_step("br restart s1", 4'b0000, 4'b0000);
    measure_duty("br restart d1", 1);

    // ON, reserved, and mode change while frozen
    en = 1'b1;
    mode = 3'd1;
    cycle();
    chk_leds("on", 4'b1111);
    mode = 3'd7;
    cycle();
    chk_leds("reserved", 4'b0000);
    en = 1'b0;
    mode = 3'd1;
    cycle();
    chk_leds("on frozen", 4'b1111);
    chk_tick("on frozen", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
